// File: rtl/pim_cfu_pkg.sv
// Shared PIM CFU definitions: opcodes, job ops, sequencer states
// and function_id field positions.
package pim_cfu_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_MAC   = 2'b10;

  localparam int FID_OP_MSB  = 9;
  localparam int FID_OP_LSB  = 8;
  localparam int FID_ROW_LSB = 0;

  typedef enum logic [1:0] {
    JOB_LOAD = 2'd0,
    JOB_READ = 2'd1,
    JOB_MAC  = 2'd2,
    JOB_RSVD = 2'd3
  } job_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_EMIT,
    ST_DONE
  } state_e;

  function automatic logic [1:0] job_opcode(input job_op_e op);
    logic [1:0] c;
    case (op)
      JOB_LOAD: c = OP_WRITE;
      JOB_READ: c = OP_READ;
      default:  c = OP_MAC;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pim_cfu_sequencer.sv
// Job-level sequencer that expands LOAD/READBACK/MAC jobs into
// single-outstanding CFU commands and streams back results.
module pim_cfu_sequencer
  import pim_cfu_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int FWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [1:0]        job_op,
  input  logic [AWIDTH-1:0] job_addr,
  input  logic [AWIDTH:0]   job_count,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DWIDTH-1:0] res_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [FWIDTH-1:0] cmd_payload_function_id,
  output logic [DWIDTH-1:0] cmd_payload_inputs_0,
  output logic [DWIDTH-1:0] cmd_payload_inputs_1,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [DWIDTH-1:0] rsp_payload_outputs_0,
  input  logic              rsp_payload_response_ok,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e              r_state;
  job_op_e             r_op;
  logic [AWIDTH-1:0]   r_addr;
  logic [AWIDTH:0]     r_count;
  logic [AWIDTH:0]     r_idx;
  logic [7:0]          r_seq;
  logic                r_stop;

  logic                r_job_ready;
  logic                r_wr_ready;
  logic                r_res_valid;
  logic [DWIDTH-1:0]   r_res_data;
  logic                r_cmd_valid;
  logic [FWIDTH-1:0]   r_fid;
  logic [DWIDTH-1:0]   r_in0;
  logic [DWIDTH-1:0]   r_in1;
  logic                r_rsp_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  job_op_e             w_job_op;
  logic                w_job_take;
  logic [AWIDTH:0]     w_idx_inc;
  logic                w_last;
  logic                w_rsp_take;
  logic                w_emit;
  logic                w_stop;
  logic [AWIDTH-1:0]   w_row_cur;
  logic [AWIDTH-1:0]   w_row_inc;
  logic [7:0]          w_seq_inc;

  function automatic logic [FWIDTH-1:0] mk_fid(
    input job_op_e           op,
    input logic [AWIDTH-1:0] row
  );
    logic [FWIDTH-1:0] f;
    f = '0;
    f[FID_OP_MSB:FID_OP_LSB] = job_opcode(op);
    if (op != JOB_MAC) f[FID_ROW_LSB +: AWIDTH] = row;
    return f;
  endfunction

  function automatic logic [DWIDTH-1:0] mk_in0(
    input job_op_e         op,
    input logic [AWIDTH:0] idx
  );
    return (op == JOB_MAC) ? DWIDTH'(idx) : '0;
  endfunction

  assign w_job_op   = job_op_e'(job_op);
  assign w_job_take = job_valid && r_job_ready;
  assign w_idx_inc  = r_idx + 1'b1;
  assign w_last     = (w_idx_inc == r_count);
  assign w_row_cur  = r_addr + r_idx[AWIDTH-1:0];
  assign w_row_inc  = r_addr + w_idx_inc[AWIDTH-1:0];
  assign w_seq_inc  = r_seq + 8'd1;

  // ISSUE may retire its response in the same cycle as the command
  assign w_rsp_take = rsp_valid &&
    ((r_state == ST_ISSUE && cmd_ready) || r_state == ST_WAIT_RSP);
  assign w_emit = (r_op == JOB_READ) || (r_op == JOB_MAC && w_last);
  assign w_stop = w_last || !rsp_payload_response_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= JOB_LOAD;
      r_addr      <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_seq       <= '0;
      r_stop      <= 1'b0;
      r_job_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_cmd_valid <= 1'b0;
      r_fid       <= '0;
      r_in0       <= '0;
      r_in1       <= '0;
      r_rsp_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_job_ready <= 1'b1;
          if (w_job_take) begin
            r_job_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_op        <= w_job_op;
            r_addr      <= job_addr;
            r_count     <= job_count;
            r_idx       <= '0;
            r_seq       <= w_seq_inc;
            r_stop      <= 1'b0;
            r_in1       <= DWIDTH'(w_seq_inc);
            if (job_count == '0 || w_job_op == JOB_RSVD) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              if (w_job_op == JOB_RSVD) r_err <= 1'b1;
            end else if (w_job_op == JOB_LOAD) begin
              r_state    <= ST_FETCH;
              r_wr_ready <= 1'b1;
            end else begin
              r_state     <= ST_ISSUE;
              r_cmd_valid <= 1'b1;
              r_rsp_ready <= 1'b1;
              r_fid       <= mk_fid(w_job_op, job_addr);
              r_in0       <= '0;
            end
          end
        end
        ST_FETCH: begin
          if (wr_valid) begin
            r_wr_ready  <= 1'b0;
            r_state     <= ST_ISSUE;
            r_cmd_valid <= 1'b1;
            r_rsp_ready <= 1'b1;
            r_fid       <= mk_fid(r_op, w_row_cur);
            r_in0       <= wr_data;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            if (!rsp_valid) r_state <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
        end
        ST_EMIT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (r_stop) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_ISSUE;
              r_cmd_valid <= 1'b1;
              r_rsp_ready <= 1'b1;
              r_fid       <= mk_fid(r_op, w_row_cur);
              r_in0       <= mk_in0(r_op, r_idx);
            end
          end
        end
        ST_DONE: begin
          r_busy      <= 1'b0;
          r_job_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // a failed response still completes, then the job aborts
      if (w_rsp_take) begin
        r_idx       <= w_idx_inc;
        r_rsp_ready <= 1'b0;
        if (!rsp_payload_response_ok) r_err <= 1'b1;
        if (w_emit) begin
          r_state     <= ST_EMIT;
          r_res_valid <= 1'b1;
          r_res_data  <= rsp_payload_outputs_0;
          r_stop      <= w_stop;
        end else if (w_stop) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end else if (r_op == JOB_LOAD) begin
          r_state    <= ST_FETCH;
          r_wr_ready <= 1'b1;
        end else begin
          r_state     <= ST_ISSUE;
          r_cmd_valid <= 1'b1;
          r_rsp_ready <= 1'b1;
          r_fid       <= mk_fid(r_op, w_row_inc);
          r_in0       <= mk_in0(r_op, w_idx_inc);
        end
      end
    end
  end

  assign job_ready               = r_job_ready;
  assign wr_ready                = r_wr_ready;
  assign res_valid               = r_res_valid;
  assign res_data                = r_res_data;
  assign cmd_valid               = r_cmd_valid;
  assign cmd_payload_function_id = r_fid;
  assign cmd_payload_inputs_0    = r_in0;
  assign cmd_payload_inputs_1    = r_in1;
  assign rsp_ready               = r_rsp_ready;
  assign busy                    = r_busy;
  assign done                    = r_done;
  assign err                     = r_err;

endmodule

// File: tb/tb_pim_cfu_sequencer.sv
// Randomized bench for pim_cfu_sequencer with a job-level
// reference model, a randomized CFU responder and a result sink.
module tb_pim_cfu_sequencer;
  import pim_cfu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int FW = 10;
  localparam int NONE = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [1:0]    job_op = '0;
  logic [AW-1:0] job_addr = '0;
  logic [AW:0]   job_count = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [FW-1:0] fid;
  logic [DW-1:0] in0;
  logic [DW-1:0] in1;
  logic          rsp_valid = 1'b0;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data = '0;
  logic          rsp_ok = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  pim_cfu_sequencer #(.DWIDTH(DW), .AWIDTH(AW), .FWIDTH(FW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .job_valid               (job_valid),
    .job_ready               (job_ready),
    .job_op                  (job_op),
    .job_addr                (job_addr),
    .job_count               (job_count),
    .wr_valid                (wr_valid),
    .wr_ready                (wr_ready),
    .wr_data                 (wr_data),
    .res_valid               (res_valid),
    .res_ready               (res_ready),
    .res_data                (res_data),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_data),
    .rsp_payload_response_ok (rsp_ok),
    .busy                    (busy),
    .done                    (done),
    .err                     (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [79:0] got,
                     input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [FW-1:0] cq_fid[$];
  logic [31:0]   cq_in0[$];
  logic [31:0]   cq_in1[$];
  logic [31:0]   rq[$];
  logic [31:0]   resq[$];
  logic [31:0]   wq[$];

  int cfg_comb = 0, cfg_rdy = 100, cfg_dmin = 0, cfg_dmax = 0;
  int cfg_wr = 100, cfg_stall = 0, cfg_res = 100;
  int job_err_at = NONE, rsp_idx = 0, issue_cyc = 0;

  bit          pend = 0;
  int          pend_dly = 0;
  logic [31:0] pend_data = '0;
  bit          pend_ok = 0;
  bit          cmd_hold = 0;
  logic [73:0] cmd_held = '0;
  bit          res_hold = 0;
  logic [31:0] res_held = '0;
  int          res_wait = 0;

  int   seq_m = 0;
  logic err_m = 1'b0;

  // CFU responder, write-data source and result sink
  always @(negedge clk) begin
    bit ok_cur;
    if (reset) begin
      pend = 0; cmd_hold = 0; res_hold = 0; res_wait = 0;
      cmd_ready = 0; rsp_valid = 0; rsp_ok = 0; rsp_data = '0;
      wr_valid = 0; res_ready = 0;
    end else begin
      if (cmd_hold) begin
        chk("cmd_hold_valid", 80'(cmd_valid), 80'(1));
        chk("cmd_hold_payload", 80'({fid, in0, in1}), 80'(cmd_held));
      end
      if (res_hold) begin
        chk("res_hold_valid", 80'(res_valid), 80'(1));
        chk("res_hold_data", 80'(res_data), 80'(res_held));
      end
      if (cmd_valid) issue_cyc++;
      cmd_ready = 0; rsp_valid = 0; rsp_ok = 0;
      rsp_data = $urandom;
      ok_cur = (rsp_idx != job_err_at);
      if (pend) begin
        if (pend_dly > 0) pend_dly--;
        else begin
          rsp_valid = 1; rsp_data = pend_data; rsp_ok = pend_ok;
          if (rsp_ready) begin
            rq.push_back(pend_data); pend = 0; rsp_idx++;
          end
        end
      end else begin
        cmd_ready = ($urandom_range(99) < 32'(cfg_rdy));
        if (cfg_comb != 0) begin
          rsp_valid = cmd_valid; rsp_ok = ok_cur;
        end
        if (cmd_valid && cmd_ready) begin
          cq_fid.push_back(fid); cq_in0.push_back(in0);
          cq_in1.push_back(in1);
          if (cfg_comb != 0) begin
            rq.push_back(rsp_data); rsp_idx++;
          end else begin
            pend = 1; pend_ok = ok_cur; pend_data = $urandom;
            pend_dly = int'($urandom_range(cfg_dmax, cfg_dmin));
          end
        end
      end
      cmd_hold = cmd_valid && !cmd_ready;
      cmd_held = {fid, in0, in1};
      wr_valid = 0;
      if (wq.size() > 0 && $urandom_range(99) < 32'(cfg_wr)) begin
        wr_valid = 1; wr_data = wq[0];
        if (wr_ready) void'(wq.pop_front());
      end
      res_ready = (res_wait >= cfg_stall) &&
                  ($urandom_range(99) < 32'(cfg_res));
      if (res_valid && res_ready) begin
        resq.push_back(res_data); res_wait = 0;
      end else if (res_valid) res_wait++;
      res_hold = res_valid && !res_ready;
      res_held = res_data;
    end
  end

  task automatic set_mode(input int comb, input int rdy, input int dmin,
                          input int dmax, input int wr, input int stall,
                          input int resp);
    cfg_comb = comb; cfg_rdy = rdy; cfg_dmin = dmin; cfg_dmax = dmax;
    cfg_wr = wr; cfg_stall = stall; cfg_res = resp;
  endtask

  task automatic start_job(input int op, input int addr, input int cnt,
                           input int e_at);
    int cyc;
    cq_fid.delete(); cq_in0.delete(); cq_in1.delete();
    rq.delete(); resq.delete();
    rsp_idx = 0; job_err_at = e_at; issue_cyc = 0;
    cyc = 0;
    while (!job_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("job_rdy", 80'(job_ready), 80'(1));
    job_valid = 1; job_op = 2'(op); job_addr = AW'(addr);
    job_count = (AW+1)'(cnt);
    @(negedge clk);
    job_valid = 0;
    seq_m = (seq_m + 1) % 256;
    chk("busy_acc", 80'(busy), 80'(1));
  endtask

  task automatic run_job(input int op, input int addr, input int cnt,
                         input int e_at);
    int n, cyc, opc, row;
    logic [31:0] words[$];
    logic [31:0] exp_res[$];
    logic [31:0] w;
    wq.delete();
    if (op == 0)
      for (int k = 0; k < cnt; k++) begin
        w = $urandom; words.push_back(w); wq.push_back(w);
      end
    start_job(op, addr, cnt, e_at);
    cyc = 0;
    while (!done && cyc < 4000) begin @(negedge clk); cyc++; end
    chk("done", 80'(done), 80'(1));
    chk("busy_done", 80'(busy), 80'(1));
    @(negedge clk);
    chk("done_pulse", 80'(done), 80'(0));
    chk("busy_end", 80'(busy), 80'(0));
    n = (op == 3) ? 0 : cnt;
    if (e_at < n) n = e_at + 1;
    if (op == 3 || (cnt > 0 && e_at < cnt)) err_m = 1'b1;
    chk("ncmd", 80'(cq_fid.size()), 80'(n));
    opc = (op == 0) ? 0 : ((op == 1) ? 1 : 2);
    for (int k = 0; k < n && k < cq_fid.size(); k++) begin
      row = (addr + k) % 256;
      chk("cmd_fid", 80'(cq_fid[k]),
          80'(opc * 256 + ((op == 2) ? 0 : row)));
      if (op == 0) chk("cmd_wdata", 80'(cq_in0[k]), 80'(words[k]));
      if (op == 2) chk("cmd_step", 80'(cq_in0[k]), 80'(k));
      chk("cmd_seq", 80'(cq_in1[k]), 80'(seq_m));
    end
    if (op == 1)
      for (int k = 0; k < n && k < rq.size(); k++) exp_res.push_back(rq[k]);
    if (op == 2 && cnt > 0 && n == cnt && rq.size() >= n)
      exp_res.push_back(rq[n-1]);
    chk("nres", 80'(resq.size()), 80'(exp_res.size()));
    for (int k = 0; k < resq.size() && k < exp_res.size(); k++)
      chk("res_data", 80'(resq[k]), 80'(exp_res[k]));
    chk("err", 80'(err), 80'(err_m));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    @(negedge clk);
    chk("rst_job_ready", 80'(job_ready), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done), 80'(0));
    chk("rst_err", 80'(err), 80'(0));
    chk("rst_cmd_valid", 80'(cmd_valid), 80'(0));
    chk("rst_wr_ready", 80'(wr_ready), 80'(0));
    chk("rst_res_valid", 80'(res_valid), 80'(0));
    chk("rst_rsp_ready", 80'(rsp_ready), 80'(0));
    chk("rst_payload", 80'({fid, in0, in1}), 80'(0));
    chk("rst_res_data", 80'(res_data), 80'(0));
    reset = 0;
    @(negedge clk);
    chk("post_rst_ready", 80'(job_ready), 80'(1));

    set_mode(0, 100, 0, 0, 100, 0, 100);
    run_job(0, 'h10, 3, NONE);
    set_mode(0, 70, 0, 3, 100, 0, 100);
    run_job(1, 'hFE, 4, NONE);
    set_mode(1, 100, 0, 0, 100, 0, 100);
    run_job(2, 0, 32, NONE);
    chk("mac_issue_cyc", 80'(issue_cyc), 80'(32));
    set_mode(0, 40, 0, 4, 50, 5, 60);
    run_job(1, 'h33, 6, NONE);
    run_job(0, 'hFD, 5, NONE);
    set_mode(1, 50, 0, 0, 100, 5, 100);
    run_job(2, 0, 7, NONE);
    set_mode(0, 100, 0, 1, 100, 0, 100);
    run_job(1, 'h40, 0, NONE);
    run_job(1, 'h40, 4, 1);
    run_job(0, 'h20, 2, NONE);

    // reset while a response is outstanding
    set_mode(0, 100, 20, 20, 100, 0, 100);
    start_job(1, 5, 4, NONE);
    cyc = 0;
    while (cq_fid.size() == 0 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("rst_cmd_seen", 80'(cq_fid.size()), 80'(1));
    @(negedge clk);
    chk("pre_rst_wait", 80'({busy, rsp_ready, cmd_valid}), 80'(3'b110));
    chk("pre_rst_err", 80'(err), 80'(err_m));
    reset = 1;
    @(negedge clk);
    chk("mid_rst_cmd_valid", 80'(cmd_valid), 80'(0));
    chk("mid_rst_busy", 80'(busy), 80'(0));
    chk("mid_rst_err", 80'(err), 80'(0));
    chk("mid_rst_job_ready", 80'(job_ready), 80'(0));
    @(negedge clk);
    reset = 0;
    err_m = 1'b0; seq_m = 0;
    @(negedge clk);
    chk("rst_rel_ready", 80'(job_ready), 80'(1));

    set_mode(0, 100, 0, 0, 100, 0, 100);
    run_job(1, 'h80, 2, NONE);
    run_job(3, 'h00, 3, NONE);

    for (int j = 0; j < 25; j++) begin
      int op, cnt, e_at;
      op = int'($urandom_range(3));
      cnt = int'($urandom_range(12));
      if (op == 2 && $urandom_range(1) == 1) cnt = int'($urandom_range(40));
      e_at = ($urandom_range(3) == 0) ? int'($urandom_range(cnt)) : NONE;
      set_mode(int'($urandom_range(1)), int'($urandom_range(100, 30)),
               0, int'($urandom_range(3)), int'($urandom_range(100, 30)),
               int'($urandom_range(3)), int'($urandom_range(100, 30)));
      run_job(op, int'($urandom_range(255)), cnt, e_at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
